// File: rtl/uart_tx_if.sv
// CPU-side bus of the UART transmitter.
//   wrn      active-low write strobe; a byte is taken on each falling edge
//   d_in     byte to send, sampled together with the write
//   ovr_clr  synchronous clear of the sticky overrun flag
//   txd      serial line, idle high
//   t_empty  FIFO empty and no frame in progress
//   t_full   FIFO holds its full depth of bytes
//   t_busy   frame in progress
//   overrun  sticky: a write was dropped because the FIFO was full
interface uart_tx_if;
  logic       wrn;
  logic [7:0] d_in;
  logic       ovr_clr;
  logic       txd;
  logic       t_empty;
  logic       t_full;
  logic       t_busy;
  logic       overrun;

  modport master (
    output wrn, d_in, ovr_clr,
    input  txd, t_empty, t_full, t_busy, overrun
  );

  modport slave (
    input  wrn, d_in, ovr_clr,
    output txd, t_empty, t_full, t_busy, overrun
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: CPU writes bytes into a small FIFO, each byte is sent as an
// 11-bit frame (start 0, 8 data bits LSB first, even parity, stop 1), 16 clocks per bit.
//   clk16x  16x bit-rate clock, sole clock
//   clr     synchronous active-high reset (aborts any frame, flushes FIFO)
//   bus     uart_tx_if.slave: wrn/d_in/ovr_clr in; txd and status flags out, all registered
module uart_tx #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic     clk16x,
  input  logic     clr,
  uart_tx_if.slave bus
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CountFull = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  logic [7:0]            fifo_mem [Depth];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  state_e                state_q;
  logic [3:0]            phase_q, bit_q;
  logic [10:0]           shift_q;
  logic                  wrn_q;
  logic                  txd_q, busy_q, empty_q, full_q, overrun_q;

  logic       wr_edge, wr_accept, wr_drop, frame_done, pop, busy_d;
  logic [7:0] head;

  always_comb begin
    wr_edge    = wrn_q & ~bus.wrn;
    // Full check uses the count before any same-edge pop.
    wr_accept  = wr_edge && (count_q != CountFull);
    wr_drop    = wr_edge && (count_q == CountFull);
    frame_done = (state_q == StShift) && (phase_q == 4'd15) && (bit_q == 4'd10);
    pop        = (count_q != '0) && ((state_q == StIdle) || frame_done);
    busy_d     = ((state_q == StShift) && !frame_done) || pop;
    head       = fifo_mem[rd_ptr_q];
    count_d    = count_q;
    if (wr_accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_accept && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk16x) begin
    if (!clr && wr_accept) begin
      fifo_mem[wr_ptr_q] <= bus.d_in;
    end
  end

  always_ff @(posedge clk16x) begin
    if (clr) begin
      wrn_q     <= 1'b1;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      phase_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '1;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wrn_q   <= bus.wrn;
      count_q <= count_d;
      if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;

      // Set wins over clear on the same edge.
      if (wr_drop) begin
        overrun_q <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun_q <= 1'b0;
      end

      full_q  <= (count_d == CountFull);
      empty_q <= (count_d == '0) && !busy_d;
      busy_q  <= busy_d;

      case (state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= {1'b1, ^head, head, 1'b0};
            txd_q   <= 1'b0;
            phase_q <= '0;
            bit_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (phase_q == 4'd15) begin
            phase_q <= '0;
            if (bit_q == 4'd10) begin
              // Stop bit done: chain straight into the next frame if one is queued.
              if (pop) begin
                shift_q <= {1'b1, ^head, head, 1'b0};
                txd_q   <= 1'b0;
                bit_q   <= '0;
              end else begin
                txd_q   <= 1'b1;
                state_q <= StIdle;
              end
            end else begin
              shift_q <= {1'b1, shift_q[10:1]};
              txd_q   <= shift_q[1];
              bit_q   <= bit_q + 4'd1;
            end
          end else begin
            phase_q <= phase_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.txd     = txd_q;
  assign bus.t_empty = empty_q;
  assign bus.t_full  = full_q;
  assign bus.t_busy  = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle comparison against a frame-level reference model
// (byte queue + elapsed-cycle frame timing), plus a line decoder for a loopback run.
module tb_uart_tx;
  logic clk16x = 1'b0;
  logic clr;

  uart_tx_if bus ();

  uart_tx #(.DEPTH_LOG2(2)) dut (
    .clk16x (clk16x),
    .clr    (clr),
    .bus    (bus)
  );

  always #5 clk16x = ~clk16x;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  // Reference model state
  logic [7:0] m_q[$];
  bit         m_busy, m_ovr, m_wrn_prev;
  int         m_elapsed;
  logic [7:0] m_frame;

  // Line decoder state
  bit          rx_en, rx_busy;
  int          rx_cnt, rx_got, rx_err;
  logic [10:0] rx_bits;
  logic [7:0]  rx_expect;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic model_step(input bit c, input bit w, input bit o, input logic [7:0] d);
    bit wr_edge, was_full;
    if (c) begin
      m_q.delete();
      m_busy     = 1'b0;
      m_ovr      = 1'b0;
      m_wrn_prev = 1'b1;
      m_elapsed  = 0;
    end else begin
      wr_edge    = m_wrn_prev && !w;
      was_full   = (m_q.size() == 4);
      m_wrn_prev = w;
      if (m_busy) begin
        m_elapsed++;
        if (m_elapsed == 176) m_busy = 1'b0;
      end
      if (!m_busy && m_q.size() != 0) begin
        m_frame   = m_q.pop_front();
        m_busy    = 1'b1;
        m_elapsed = 0;
      end
      if (wr_edge && was_full) begin
        m_ovr = 1'b1;
      end else begin
        if (wr_edge) m_q.push_back(d);
        if (o) m_ovr = 1'b0;
      end
    end
  endtask

  task automatic rx_step(input bit c);
    if (c || !rx_en) begin
      rx_busy = 1'b0;
      return;
    end
    if (!rx_busy) begin
      if (bus.txd == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
    end
    if (rx_busy && (rx_cnt % 16) == 8) begin
      rx_bits[rx_cnt/16] = bus.txd;
      if (rx_cnt / 16 == 10) begin
        rx_busy = 1'b0;
        if (rx_bits[0] == 1'b0 && rx_bits[10] == 1'b1 && ^rx_bits[9:1] == 1'b0) begin
          check_eq("rx_byte", {24'd0, rx_bits[8:1]}, {24'd0, rx_expect});
          rx_expect++;
          rx_got++;
        end else begin
          rx_err++;
        end
      end
    end
  endtask

  task automatic tick(input bit c, input bit w, input logic [7:0] d, input bit o);
    logic exp_txd;
    clr         = c;
    bus.wrn     = w;
    bus.d_in    = d;
    bus.ovr_clr = o;
    @(posedge clk16x);
    model_step(c, w, o, d);
    #1;
    exp_txd = m_busy ? frame_bit(m_frame, m_elapsed / 16) : 1'b1;
    check_eq("txd/empty/full/busy/ovr",
             {27'd0, bus.txd, bus.t_empty, bus.t_full, bus.t_busy, bus.overrun},
             {27'd0, exp_txd, (m_q.size() == 0) && !m_busy, m_q.size() == 4, m_busy, m_ovr});
    rx_step(c);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic write_byte(input logic [7:0] b, input int low, input bit o);
    repeat (low) tick(1'b0, 1'b0, b, o);
    tick(1'b0, 1'b1, b, 1'b0);
  endtask

  initial begin
    int sent;
    logic [7:0] pats [3];
    pats[0] = 8'h07; pats[1] = 8'h00; pats[2] = 8'hFF;
    clr = 1'b1; bus.wrn = 1'b1; bus.d_in = '0; bus.ovr_clr = 1'b0;
    rx_en = 1'b0; rx_busy = 1'b0; rx_cnt = 0; rx_got = 0; rx_err = 0; rx_expect = '0;
    m_busy = 1'b0; m_ovr = 1'b0; m_wrn_prev = 1'b1; m_elapsed = 0; m_frame = '0;

    repeat (3) tick(1'b1, 1'b1, 8'h00, 1'b0);

    // Single frame, then parity patterns
    write_byte(8'h55, 1, 1'b0);
    idle(200);
    foreach (pats[i]) begin
      write_byte(pats[i], 1, 1'b0);
      idle(180);
    end

    // Back-to-back writes at idle: contiguous frames
    for (int i = 0; i < 4; i++) write_byte(8'($urandom), 1, 1'b0);
    idle(800);

    // Overrun, clear, then clear racing an overflowing write
    write_byte(8'hA1, 1, 1'b0);
    idle(20);
    for (int i = 0; i < 5; i++) write_byte(8'($urandom), 1, 1'b0);
    tick(1'b0, 1'b1, 8'h00, 1'b1);
    idle(3);
    write_byte(8'hEE, 1, 1'b1);
    idle(1000);

    // Long write strobe queues exactly one byte
    write_byte(8'h3C, 40, 1'b0);
    idle(400);

    // Reset during the parity bit of the first queued frame
    for (int i = 0; i < 3; i++) write_byte(8'($urandom), 1, 1'b0);
    idle(146);
    tick(1'b1, 1'b1, 8'h00, 1'b0);
    idle(200);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
           $urandom_range(0, 19) == 0);
    end
    tick(1'b1, 1'b1, 8'h00, 1'b0);

    // Loopback: 256 bytes with flow control, decoded from the line
    rx_en = 1'b1;
    sent  = 0;
    while (sent < 256) begin
      if (m_q.size() < 4) begin
        write_byte(sent[7:0], 1, 1'b0);
        sent++;
      end else begin
        idle(1);
      end
    end
    idle(1000);
    check_eq("rx_count", 32'(rx_got), 32'd256);
    check_eq("rx_errors", 32'(rx_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
